detector_jogada: RTL and testbench

Front-end stage that turns the four raw, bouncing player buttons into clean plays for the game circuit. Synchronizes and debounces the buttons, accepts a play only if exactly one button is held stably, and emits a one-cycle `jogada_feita` pulse with the registered one-hot value. The pulse and value drive the game circuit's `chaves`/jogada inputs directly. A button must be released, with the release also debounced, before the next play is accepted.

---
 rtl/jogo_pkg.sv | 28 ++
 rtl/sincronizador_2ff.sv | 27 ++
 rtl/detector_jogada.sv | 154 +++++++++++++++
 tb/tb_detector_jogada.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// Shared definitions for the play detector: state codes, button count and
// the default debounce window.
package jogo_pkg;

  // Number of player buttons
  localparam int LARGURA_BOTOES = 4;

  // Debounce window used in simulation; board builds override it
  localparam int DEBOUNCE_PADRAO = 4;

  // State codes, also shown on the 7-segment debug display
  localparam logic [3:0] EST_ESPERA   = 4'd0;
  localparam logic [3:0] EST_FILTRA   = 4'd1;
  localparam logic [3:0] EST_EMITE    = 4'd2;
  localparam logic [3:0] EST_INVALIDA = 4'd3;
  localparam logic [3:0] EST_SEGURA   = 4'd4;
  localparam logic [3:0] EST_SOLTA    = 4'd5;

  typedef enum logic [3:0] {
    ESPERA   = EST_ESPERA,
    FILTRA   = EST_FILTRA,
    EMITE    = EST_EMITE,
    INVALIDA = EST_INVALIDA,
    SEGURA   = EST_SEGURA,
    SOLTA    = EST_SOLTA
  } estado_t;

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous inputs, cleared to zero on reset.
module sincronizador_2ff #(
  parameter int LARGURA = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] i_dado,
  output logic [LARGURA-1:0] o_dado
);

  logic [LARGURA-1:0] r_meta;
  logic [LARGURA-1:0] r_sinc;

  // Two-stage capture to let metastability settle before use
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_meta <= {LARGURA{1'b0}};
      r_sinc <= {LARGURA{1'b0}};
    end else begin
      r_meta <= i_dado;
      r_sinc <= r_meta;
    end
  end

  assign o_dado = r_sinc;

endmodule

// File: rtl/detector_jogada.sv
// Play detector: synchronizes and debounces the four player buttons, accepts
// a play only when exactly one button is held stably, and requires a filtered
// release before the next play can be accepted.
module detector_jogada
  import jogo_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_PADRAO
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      habilitar,
  input  logic [LARGURA_BOTOES-1:0] botoes,
  output logic [LARGURA_BOTOES-1:0] jogada,
  output logic                      jogada_feita,
  output logic                      jogada_invalida,
  output logic                      ocupado,
  output logic [3:0]                db_estado
);

  // Counter is sized to hold DEBOUNCE_CYCLES; the decision compares against
  // DEBOUNCE_CYCLES-1 because the sample being evaluated is the last one.
  localparam int              CW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   C_UM  = CW'(1);
  localparam logic [CW-1:0]   C_FIM = CW'(DEBOUNCE_CYCLES - 1);
  localparam bit              JANELA_UNICA = (DEBOUNCE_CYCLES == 1);

  logic [LARGURA_BOTOES-1:0] w_s;
  logic                      w_s_nulo;
  logic                      w_s_one_hot;

  estado_t                   r_estado;
  logic [LARGURA_BOTOES-1:0] r_cand;
  logic [CW-1:0]             r_cont;
  logic [LARGURA_BOTOES-1:0] r_jogada;
  logic                      r_feita;
  logic                      r_invalida;

  sincronizador_2ff #(
    .LARGURA(LARGURA_BOTOES)
  ) u_sinc (
    .clock  (clock),
    .reset  (reset),
    .i_dado (botoes),
    .o_dado (w_s)
  );

  assign w_s_nulo    = (w_s == {LARGURA_BOTOES{1'b0}});
  assign w_s_one_hot = ($countones(w_s) == 32'sd1);

  // Main control FSM; pulses are registered on the transition into their state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado   <= ESPERA;
      r_cand     <= {LARGURA_BOTOES{1'b0}};
      r_cont     <= {CW{1'b0}};
      r_jogada   <= {LARGURA_BOTOES{1'b0}};
      r_feita    <= 1'b0;
      r_invalida <= 1'b0;
    end else begin
      r_feita    <= 1'b0;
      r_invalida <= 1'b0;
      case (r_estado)
        ESPERA: begin
          if (w_s_nulo) begin
            r_estado <= ESPERA;
          end else if (!habilitar) begin
            // A button already held when enable arrives is never accepted
            r_estado <= SEGURA;
          end else begin
            r_cand <= w_s;
            r_cont <= C_UM;
            if (!JANELA_UNICA) begin
              r_estado <= FILTRA;
            end else if (w_s_one_hot) begin
              r_estado <= EMITE;
              r_jogada <= w_s;
              r_feita  <= 1'b1;
            end else begin
              r_estado   <= INVALIDA;
              r_invalida <= 1'b1;
            end
          end
        end

        FILTRA: begin
          if (!habilitar) begin
            r_estado <= SEGURA;
          end else if (w_s_nulo) begin
            r_estado <= ESPERA;
          end else if (w_s != r_cand) begin
            // Bounce or value change restarts the window on the new value
            r_cand   <= w_s;
            r_cont   <= C_UM;
            r_estado <= FILTRA;
          end else if (r_cont >= C_FIM) begin
            // Here w_s equals r_cand, so its popcount decides validity
            if (w_s_one_hot) begin
              r_estado <= EMITE;
              r_jogada <= r_cand;
              r_feita  <= 1'b1;
            end else begin
              r_estado   <= INVALIDA;
              r_invalida <= 1'b1;
            end
          end else begin
            r_cont   <= r_cont + C_UM;
            r_estado <= FILTRA;
          end
        end

        EMITE: begin
          r_estado <= SEGURA;
        end

        INVALIDA: begin
          r_estado <= SEGURA;
        end

        SEGURA: begin
          if (!w_s_nulo) begin
            r_estado <= SEGURA;
          end else if (JANELA_UNICA) begin
            r_estado <= ESPERA;
          end else begin
            r_cont   <= C_UM;
            r_estado <= SOLTA;
          end
        end

        SOLTA: begin
          if (!w_s_nulo) begin
            r_estado <= SEGURA;
          end else if (r_cont >= C_FIM) begin
            r_estado <= ESPERA;
          end else begin
            r_cont   <= r_cont + C_UM;
            r_estado <= SOLTA;
          end
        end

        default: begin
          r_estado <= ESPERA;
        end
      endcase
    end
  end

  assign jogada          = r_jogada;
  assign jogada_feita    = r_feita;
  assign jogada_invalida = r_invalida;
  assign db_estado       = r_estado;
  assign ocupado         = (r_estado != ESPERA);

endmodule

// File: tb/tb_detector_jogada.sv
// Scoreboard bench for detector_jogada: stimulus pushes the expected pulse
// (kind, value, cycle) into a queue; a monitor pops and compares whenever the
// DUT raises jogada_feita or jogada_invalida.
module tb_detector_jogada;
  import jogo_pkg::*;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      habilitar;
  logic [LARGURA_BOTOES-1:0] botoes;
  logic [LARGURA_BOTOES-1:0] jogada;
  logic                      jogada_feita;
  logic                      jogada_invalida;
  logic                      ocupado;
  logic [3:0]                db_estado;

  detector_jogada #(.DEBOUNCE_CYCLES(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .habilitar       (habilitar),
    .botoes          (botoes),
    .jogada          (jogada),
    .jogada_feita    (jogada_feita),
    .jogada_invalida (jogada_invalida),
    .ocupado         (ocupado),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;

  // Count of rising edges seen so far
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_aval   = 0;
  int n_falhas = 0;

  typedef struct {
    int         tipo;   // 0 = jogada_feita, 1 = jogada_invalida
    logic [3:0] valor;
    int         ciclo;
  } esperado_t;

  esperado_t fila[$];
  esperado_t ev_mon;

  task automatic verifica(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_aval++;
    if (atual !== esperado) begin
      n_falhas++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, atual, esperado, cyc);
    end
  endtask

  // Expected pulse appears at edge 6 counted from the next rising edge
  task automatic espera_evento(input int tipo, input logic [3:0] v);
    esperado_t e;
    e.tipo  = tipo;
    e.valor = v;
    e.ciclo = cyc + 6;
    fila.push_back(e);
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: compare every pulse against the head of the scoreboard
  always @(negedge clock) begin
    if (!reset && (jogada_feita || jogada_invalida)) begin
      if (fila.size() == 0) begin
        verifica("pulso_inesperado", {30'd0, jogada_feita, jogada_invalida}, 32'd0);
      end else begin
        ev_mon = fila.pop_front();
        verifica("tipo_pulso", {30'd0, jogada_feita, jogada_invalida},
                 (ev_mon.tipo == 1) ? 32'd1 : 32'd2);
        verifica("ciclo_pulso", cyc, ev_mon.ciclo);
        verifica("jogada_no_pulso", {28'd0, jogada}, {28'd0, ev_mon.valor});
      end
    end
  end

  logic [3:0] seq[$];
  logic [3:0] seq_esp [6];

  initial begin
    seq_esp = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd0};
    reset     = 1'b1;
    habilitar = 1'b0;
    botoes    = 4'b0000;
    ciclos(3);
    verifica("reset_jogada", {28'd0, jogada}, 32'd0);
    verifica("reset_feita", {31'd0, jogada_feita}, 32'd0);
    verifica("reset_invalida", {31'd0, jogada_invalida}, 32'd0);
    verifica("reset_ocupado", {31'd0, ocupado}, 32'd0);
    verifica("reset_estado", {28'd0, db_estado}, 32'd0);
    reset     = 1'b0;
    habilitar = 1'b1;
    ciclos(2);

    // Clean press of 0010, recording the state sequence
    botoes = 4'b0010;
    espera_evento(0, 4'b0010);
    seq.push_back(db_estado);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) botoes = 4'b0000;
      @(negedge clock);
      if (db_estado != seq[$]) seq.push_back(db_estado);
    end
    verifica("seq_tamanho", seq.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      verifica($sformatf("seq_estado_%0d", i),
               (i < seq.size()) ? {28'd0, seq[i]} : 32'hFF, {28'd0, seq_esp[i]});
    end
    verifica("limpa_jogada", {28'd0, jogada}, 32'h2);

    // Bounce on 0100, then stable hold
    for (int k = 0; k < 2; k++) begin
      botoes = 4'b0100;
      ciclos(2);
      botoes = 4'b0000;
      ciclos(2);
    end
    botoes = 4'b0100;
    espera_evento(0, 4'b0100);
    ciclos(10);
    botoes = 4'b0000;
    ciclos(10);
    verifica("bounce_jogada", {28'd0, jogada}, 32'h4);

    // Invalid two-button press; jogada keeps 0100
    botoes = 4'b0011;
    espera_evento(1, 4'b0100);
    ciclos(8);
    verifica("invalida_segura", {28'd0, db_estado}, 32'd4);
    botoes = 4'b0000;
    ciclos(5);
    verifica("invalida_solta", {28'd0, db_estado}, 32'd5);
    ciclos(1);
    verifica("invalida_espera", {28'd0, db_estado}, 32'd0);
    verifica("invalida_jogada", {28'd0, jogada}, 32'h4);

    // Enable gating: button held before enable is never accepted
    habilitar = 1'b0;
    botoes    = 4'b1000;
    ciclos(6);
    verifica("gate_segura_sem_hab", {28'd0, db_estado}, 32'd4);
    habilitar = 1'b1;
    ciclos(8);
    verifica("gate_segura_com_hab", {28'd0, db_estado}, 32'd4);
    verifica("gate_ocupado", {31'd0, ocupado}, 32'd1);
    botoes = 4'b0000;
    ciclos(10);
    verifica("gate_espera", {28'd0, db_estado}, 32'd0);
    botoes = 4'b1000;
    espera_evento(0, 4'b1000);
    ciclos(8);
    botoes = 4'b0000;
    ciclos(10);

    // Reset during FILTRA, released with the button still held
    botoes = 4'b0001;
    ciclos(3);
    verifica("rst_em_filtra", {28'd0, db_estado}, 32'd1);
    #1 reset = 1'b1;
    #1;
    verifica("rst_jogada", {28'd0, jogada}, 32'd0);
    verifica("rst_feita", {31'd0, jogada_feita}, 32'd0);
    verifica("rst_invalida", {31'd0, jogada_invalida}, 32'd0);
    verifica("rst_ocupado", {31'd0, ocupado}, 32'd0);
    verifica("rst_estado", {28'd0, db_estado}, 32'd0);
    ciclos(2);
    reset = 1'b0;
    espera_evento(0, 4'b0001);
    ciclos(8);
    botoes = 4'b0000;
    ciclos(10);

    // Back-to-back plays with a 4-cycle gap
    botoes = 4'b0001;
    espera_evento(0, 4'b0001);
    ciclos(8);
    botoes = 4'b0000;
    ciclos(4);
    botoes = 4'b0010;
    espera_evento(0, 4'b0010);
    ciclos(8);
    botoes = 4'b0000;
    ciclos(10);
    verifica("b2b_jogada", {28'd0, jogada}, 32'h2);

    verifica("pulsos_pendentes", fila.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_aval, n_falhas);
    $finish;
  end

endmodule
